// File: rtl/nios2_onchip_mem_arbiter_if.sv
// Avalon-MM master-side bundle for one requester of the on-chip RAM arbiter.
interface nios2_onchip_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                lock;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata, lock,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata, lock,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/nios2_onchip_mem_arbiter.sv
// Two-master round-robin arbiter (with lock) in front of a single-port
// on-chip RAM; read data is steered back to the issuer via a latency-matched
// {valid,id} shift register.
module nios2_onchip_mem_arbiter #(
   parameter int unsigned ADDR_W       = 14,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   nios2_onchip_mem_arbiter_if.slave m0,
   nios2_onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]    mem_address,
   output logic [DATA_W/8-1:0]  mem_byteenable,
   output logic                 mem_chipselect,
   output logic                 mem_write,
   output logic [DATA_W-1:0]    mem_writedata,
   output logic                 mem_clken,
   input  logic [DATA_W-1:0]    mem_readdata
);

   localparam int unsigned RL = READ_LATENCY;

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic [RL-1:0]   rd_valid_q, rd_valid_d;
   logic [RL-1:0]   rd_id_q, rd_id_d;

   logic            req0_c, req1_c;
   logic            grant0_c, grant1_c;
   logic            rd_load_c;

   // Grant decision: lock owner only, otherwise round-robin on ties.
   // Nothing is granted while reset is held.
   always_comb begin
      req0_c   = (m0.read | m0.write) & ~reset;
      req1_c   = (m1.read | m1.write) & ~reset;
      grant0_c = 1'b0;
      grant1_c = 1'b0;
      case (state_q)
         ST_LOCK0: grant0_c = req0_c;
         ST_LOCK1: grant1_c = req1_c;
         default: begin
            grant0_c = req0_c & (~req1_c | last_grant_q);
            grant1_c = req1_c & (~req0_c | ~last_grant_q);
         end
      endcase
   end

   // Next state and last-grant tracking; lock is taken/released per access.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      if (grant0_c) begin
         last_grant_d = 1'b0;
         state_d      = m0.lock ? ST_LOCK0 : ST_ARB;
      end else if (grant1_c) begin
         last_grant_d = 1'b1;
         state_d      = m1.lock ? ST_LOCK1 : ST_ARB;
      end
   end

   // RAM-side mux of the granted master; read+write together counts as write.
   always_comb begin
      mem_address    = m0.address;
      mem_byteenable = m0.byteenable;
      mem_writedata  = m0.writedata;
      mem_chipselect = grant0_c | grant1_c;
      mem_write      = 1'b0;
      if (grant1_c) begin
         mem_address    = m1.address;
         mem_byteenable = m1.byteenable;
         mem_writedata  = m1.writedata;
         mem_write      = m1.write;
      end else if (grant0_c) begin
         mem_write      = m0.write;
      end
   end

   // Read-return tracker: shift in {valid,id} for every granted read.
   always_comb begin
      rd_load_c     = (grant0_c & ~m0.write) | (grant1_c & ~m1.write);
      rd_valid_d    = rd_valid_q << 1;
      rd_valid_d[0] = rd_load_c;
      rd_id_d       = rd_id_q << 1;
      rd_id_d[0]    = grant1_c;
   end

   // State registers; reset drops in-flight reads and releases any lock.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_ARB;
         last_grant_q <= 1'b1;
         rd_valid_q   <= '0;
         rd_id_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rd_valid_q   <= rd_valid_d;
         rd_id_q      <= rd_id_d;
      end
   end

   assign mem_clken        = 1'b1;
   assign m0.waitrequest   = ~grant0_c;
   assign m1.waitrequest   = ~grant1_c;
   assign m0.readdata      = mem_readdata;
   assign m1.readdata      = mem_readdata;
   assign m0.readdatavalid = rd_valid_q[RL-1] & ~rd_id_q[RL-1] & ~reset;
   assign m1.readdatavalid = rd_valid_q[RL-1] &  rd_id_q[RL-1] & ~reset;

endmodule

// File: tb/tb_nios2_onchip_mem_arbiter.sv
// Bench for the two-master on-chip RAM arbiter: RAM model, reference model,
// constant vector table, directed multi-cycle sequences and random traffic.
module tb_nios2_onchip_mem_arbiter;

   localparam int unsigned AW    = 14;
   localparam int unsigned DW    = 32;
   localparam int unsigned BW    = DW / 8;
   localparam int unsigned RL    = 1;
   localparam int unsigned DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   nios2_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i0 ();
   nios2_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i1 ();

   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_byteenable;
   logic          mem_chipselect;
   logic          mem_write;
   logic [DW-1:0] mem_writedata;
   logic          mem_clken;
   logic [DW-1:0] mem_readdata;

   nios2_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
      .clk            (clk),
      .reset          (reset),
      .m0             (i0.slave),
      .m1             (i1.slave),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata)
   );

   // Unwritten words read back as a pattern derived from their address.
   function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
      return 32'h5A5A_0000 | DW'(a);
   endfunction

   function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [BW-1:0] be);
      logic [DW-1:0] r = old;
      for (int b = 0; b < int'(BW); b++)
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // RAM model driven only by the DUT's mem_* port.
   bit   [DW-1:0] ram_mem [DEPTH];
   bit            ram_set [DEPTH];
   logic [DW-1:0] rpipe   [RL];

   function automatic logic [DW-1:0] ram_rd(logic [AW-1:0] a);
      return ram_set[a] ? ram_mem[a] : init_word(a);
   endfunction

   always @(posedge clk) begin
      if (mem_chipselect && mem_write) begin
         ram_mem[mem_address] <= merge(ram_rd(mem_address), mem_writedata, mem_byteenable);
         ram_set[mem_address] <= 1'b1;
      end
      rpipe[0] <= ram_rd(mem_address);
      for (int i = 1; i < int'(RL); i++) rpipe[i] <= rpipe[i-1];
   end
   assign mem_readdata = rpipe[RL-1];

   // Reference model: shadow memory, lock owner, last winner, return queue.
   bit [DW-1:0] sh_mem [DEPTH];
   bit          sh_set [DEPTH];
   int owner = -1;
   int last  = 1;
   int cyc   = 0;
   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } ret_t;
   ret_t retq[$];

   function automatic logic [DW-1:0] sh_rd(logic [AW-1:0] a);
      return sh_set[a] ? sh_mem[a] : init_word(a);
   endfunction

   function automatic int pick(bit q0, bit q1);
      if (reset) return -1;
      if (owner == 0) return q0 ? 0 : -1;
      if (owner == 1) return q1 ? 1 : -1;
      if (q0 && q1) return 1 - last;
      if (q0) return 0;
      if (q1) return 1;
      return -1;
   endfunction

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   logic          obs_w0, obs_w1, obs_cs, obs_we, obs_v0, obs_v1;
   logic [DW-1:0] obs_rd0, obs_rd1;
   logic [AW-1:0] obs_a;
   logic [BW-1:0] obs_be;

   task automatic set_m(int n, bit rd, bit wr, bit lk, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] d);
      if (n == 0) begin
         i0.read = rd; i0.write = wr; i0.lock = lk; i0.address = a; i0.byteenable = be; i0.writedata = d;
      end else begin
         i1.read = rd; i1.write = wr; i1.lock = lk; i1.address = a; i1.byteenable = be; i1.writedata = d;
      end
   endtask

   task automatic idle();
      set_m(0, 0, 0, 0, '0, '0, '0);
      set_m(1, 0, 0, 0, '0, '0, '0);
   endtask

   // One clock: sample and model-check just after the negedge drive, then advance the model.
   task automatic tick();
      int            g;
      bit            e0, e1, wr, lk;
      logic [DW-1:0] ed;
      logic [AW-1:0] a;
      logic [BW-1:0] be;
      logic [DW-1:0] wd;
      #1;
      g  = pick(i0.read | i0.write, i1.read | i1.write);
      e0 = 1'b0; e1 = 1'b0; ed = '0;
      if (!reset && retq.size() > 0 && retq[0].due == cyc) begin
         e0 = (retq[0].id == 0);
         e1 = (retq[0].id == 1);
         ed = retq[0].data;
      end
      obs_w0 = i0.waitrequest;   obs_w1 = i1.waitrequest;
      obs_cs = mem_chipselect;   obs_we = mem_write;
      obs_v0 = i0.readdatavalid; obs_v1 = i1.readdatavalid;
      obs_rd0 = i0.readdata;     obs_rd1 = i1.readdata;
      obs_a  = mem_address;      obs_be = mem_byteenable;
      wr = (g == 0) ? i0.write : (g == 1) ? i1.write : 1'b0;
      lk = (g == 0) ? i0.lock  : (g == 1) ? i1.lock  : 1'b0;
      a  = (g == 1) ? i1.address    : i0.address;
      be = (g == 1) ? i1.byteenable : i0.byteenable;
      wd = (g == 1) ? i1.writedata  : i0.writedata;
      check("m0_waitrequest", DW'(obs_w0), DW'(g != 0));
      check("m1_waitrequest", DW'(obs_w1), DW'(g != 1));
      check("mem_chipselect", DW'(obs_cs), DW'(g >= 0));
      check("mem_write", DW'(obs_we), DW'(wr));
      if (g >= 0) begin
         check("mem_address", DW'(obs_a), DW'(a));
         check("mem_byteenable", DW'(obs_be), DW'(be));
         if (wr) check("mem_writedata", mem_writedata, wd);
      end
      check("m0_readdatavalid", DW'(obs_v0), DW'(e0));
      check("m1_readdatavalid", DW'(obs_v1), DW'(e1));
      if (e0) check("m0_readdata", obs_rd0, ed);
      if (e1) check("m1_readdata", obs_rd1, ed);
      @(posedge clk);
      if (retq.size() > 0 && retq[0].due == cyc) void'(retq.pop_front());
      if (reset) begin
         retq.delete();
         owner = -1;
         last  = 1;
      end else if (g >= 0) begin
         if (wr) begin
            sh_mem[a] = merge(sh_rd(a), wd, be);
            sh_set[a] = 1'b1;
         end else begin
            retq.push_back('{cyc + int'(RL), g, sh_rd(a)});
         end
         owner = lk ? g : -1;
         last  = g;
      end
      cyc++;
      @(negedge clk);
   endtask

   typedef struct {
      bit            r0, w0, l0;
      logic [AW-1:0] a0;
      logic [BW-1:0] be0;
      bit            r1, w1, l1;
      logic [AW-1:0] a1;
      logic [BW-1:0] be1;
      bit            ew0, ew1, ecs, ewe;
      logic [AW-1:0] ea;
      logic [BW-1:0] ebe;
   } vec_t;

   localparam logic [DW-1:0] WD0 = 32'hD0D1_D2D3;
   localparam logic [DW-1:0] WD1 = 32'hE0E1_E2E3;

   vec_t tbl [16];
   int   cnt0, cnt1;
   logic [DW-1:0] got0, got1;
   bit   hold0;

   initial begin
      // r0 w0 l0 a0 be0 | r1 w1 l1 a1 be1 | wait0 wait1 cs we addr be
      tbl[0]  = '{0,1,0,14'h100,4'h3, 0,1,0,14'h200,4'hC, 0,1,1,1,14'h100,4'h3};
      tbl[1]  = '{0,1,0,14'h101,4'h3, 0,1,0,14'h200,4'hC, 1,0,1,1,14'h200,4'hC};
      tbl[2]  = '{0,1,0,14'h101,4'h3, 0,1,0,14'h201,4'hC, 0,1,1,1,14'h101,4'h3};
      tbl[3]  = '{0,1,0,14'h102,4'h3, 0,1,0,14'h201,4'hC, 1,0,1,1,14'h201,4'hC};
      tbl[4]  = '{0,1,0,14'h102,4'h3, 0,1,0,14'h202,4'hC, 0,1,1,1,14'h102,4'h3};
      tbl[5]  = '{0,1,0,14'h103,4'h3, 0,1,0,14'h202,4'hC, 1,0,1,1,14'h202,4'hC};
      tbl[6]  = '{0,0,0,14'h000,4'h0, 0,0,0,14'h000,4'h0, 1,1,0,0,14'h000,4'h0};
      tbl[7]  = '{0,0,0,14'h000,4'h0, 0,1,1,14'h300,4'hF, 1,0,1,1,14'h300,4'hF};
      tbl[8]  = '{1,0,0,14'h010,4'hF, 0,0,0,14'h000,4'h0, 1,1,0,0,14'h000,4'h0};
      tbl[9]  = '{1,0,0,14'h010,4'hF, 1,0,0,14'h300,4'hF, 1,0,1,0,14'h300,4'hF};
      tbl[10] = '{1,0,0,14'h010,4'hF, 0,0,0,14'h000,4'h0, 0,1,1,0,14'h010,4'hF};
      tbl[11] = '{0,1,1,14'h011,4'hF, 0,0,0,14'h000,4'h0, 0,1,1,1,14'h011,4'hF};
      tbl[12] = '{0,1,0,14'h012,4'hF, 0,1,0,14'h301,4'hF, 0,1,1,1,14'h012,4'hF};
      tbl[13] = '{0,1,0,14'h013,4'hF, 0,1,0,14'h301,4'hF, 1,0,1,1,14'h301,4'hF};
      tbl[14] = '{0,0,0,14'h000,4'h0, 0,0,0,14'h000,4'h0, 1,1,0,0,14'h000,4'h0};
      tbl[15] = '{1,1,0,14'h014,4'hF, 0,0,0,14'h000,4'h0, 0,1,1,1,14'h014,4'hF};

      reset = 1'b1;
      idle();
      @(negedge clk);

      // Reset state
      tick();
      tick();
      check("rst_m0_waitrequest", DW'(obs_w0), DW'(1'b1));
      check("rst_m1_waitrequest", DW'(obs_w1), DW'(1'b1));
      check("rst_mem_chipselect", DW'(obs_cs), DW'(1'b0));
      check("rst_mem_write", DW'(obs_we), DW'(1'b0));
      check("rst_m0_readdatavalid", DW'(obs_v0), DW'(1'b0));
      check("mem_clken", DW'(mem_clken), DW'(1'b1));
      reset = 1'b0;

      // Lone m0 read of 0x0010
      for (int k = 0; k <= int'(RL); k++) begin
         if (k == 0) set_m(0, 1, 0, 0, 14'h010, 4'hF, '0); else idle();
         tick();
         if (k == 0) check("t1_m0_accept", DW'(obs_w0), DW'(1'b0));
         if (k == int'(RL)) begin
            check("t1_m0_rdv", DW'(obs_v0), DW'(1'b1));
            check("t1_m0_data", obs_rd0, 32'h5A5A_0010);
            check("t1_m1_rdv", DW'(obs_v1), DW'(1'b0));
         end
      end

      // Fresh reset so the table starts with master 0 winning the tie
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Vector table: alternating writes, lock hold/release, read+write as write
      for (int i = 0; i < 16; i++) begin
         set_m(0, tbl[i].r0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].be0, WD0);
         set_m(1, tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].be1, WD1);
         tick();
         check($sformatf("vec%0d_wait0", i), DW'(obs_w0), DW'(tbl[i].ew0));
         check($sformatf("vec%0d_wait1", i), DW'(obs_w1), DW'(tbl[i].ew1));
         check($sformatf("vec%0d_cs", i), DW'(obs_cs), DW'(tbl[i].ecs));
         check($sformatf("vec%0d_we", i), DW'(obs_we), DW'(tbl[i].ewe));
         if (tbl[i].ecs) begin
            check($sformatf("vec%0d_addr", i), DW'(obs_a), DW'(tbl[i].ea));
            check($sformatf("vec%0d_be", i), DW'(obs_be), DW'(tbl[i].ebe));
         end
      end

      // Read back byte-enabled writes from the alternating phase
      idle();
      for (int k = 0; k < 2 + int'(RL); k++) begin
         if (k == 0) set_m(0, 1, 0, 0, 14'h100, 4'hF, '0);
         else if (k == 1) set_m(0, 1, 0, 0, 14'h200, 4'hF, '0);
         else idle();
         tick();
         if (k == int'(RL)) check("rb_0x100", obs_rd0, 32'h5A5A_D2D3);
         if (k == int'(RL) + 1) check("rb_0x200", obs_rd0, 32'hE0E1_0200);
      end

      // Preload 0xA0..0xA3, then four back-to-back reads
      for (int k = 0; k < 4; k++) begin
         set_m(0, 0, 1, 0, AW'(k), 4'hF, 32'hA0 + DW'(k));
         tick();
      end
      for (int k = 0; k < 4 + int'(RL); k++) begin
         if (k < 4) set_m(0, 1, 0, 0, AW'(k), 4'hF, '0); else idle();
         tick();
         if (k >= int'(RL)) begin
            check($sformatf("b2b_rdv%0d", k - int'(RL)), DW'(obs_v0), DW'(1'b1));
            check($sformatf("b2b_data%0d", k - int'(RL)), obs_rd0, 32'hA0 + DW'(k - int'(RL)));
         end
      end

      // Interleaved reads m0@0x5, m1@0x6
      cnt0 = 0; cnt1 = 0; got0 = '0; got1 = '0;
      set_m(0, 1, 0, 0, 14'h005, 4'hF, '0);
      set_m(1, 1, 0, 0, 14'h006, 4'hF, '0);
      tick();
      check("il_one_grant", DW'(obs_w0 ^ obs_w1), DW'(1'b1));
      hold0 = obs_w0;
      for (int k = 0; k < 2 + int'(RL); k++) begin
         if (k == 0 && hold0) set_m(1, 0, 0, 0, '0, '0, '0);
         else if (k == 0) set_m(0, 0, 0, 0, '0, '0, '0);
         else idle();
         tick();
         if (obs_v0) begin cnt0++; got0 = obs_rd0; end
         if (obs_v1) begin cnt1++; got1 = obs_rd1; end
      end
      check("il_m0_count", DW'(cnt0), DW'(1));
      check("il_m1_count", DW'(cnt1), DW'(1));
      check("il_m0_data", got0, 32'h5A5A_0005);
      check("il_m1_data", got1, 32'h5A5A_0006);

      // Reset right after an accepted read
      set_m(0, 1, 0, 0, 14'h020, 4'hF, '0);
      tick();
      check("rr_accept", DW'(obs_w0), DW'(1'b0));
      idle();
      reset = 1'b1;
      tick();
      check("rr_rdv0_in_reset", DW'(obs_v0), DW'(1'b0));
      check("rr_rdv1_in_reset", DW'(obs_v1), DW'(1'b0));
      reset = 1'b0;
      set_m(1, 1, 0, 0, 14'h021, 4'hF, '0);
      tick();
      check("rr_m1_grant", DW'(obs_w1), DW'(1'b0));
      cnt0 = 0; cnt1 = 0;
      idle();
      for (int k = 0; k < int'(RL) + 1; k++) begin
         tick();
         if (obs_v0) cnt0++;
         if (obs_v1) cnt1++;
      end
      check("rr_m0_none", DW'(cnt0), DW'(0));
      check("rr_m1_one", DW'(cnt1), DW'(1));

      // Random traffic against the reference model
      for (int c = 0; c < 600; c++) begin
         int k0, k1;
         reset = ($urandom_range(0, 59) == 0);
         k0 = $urandom_range(0, 3);
         k1 = $urandom_range(0, 3);
         set_m(0, k0[0], k0[1], $urandom_range(0, 3) == 0, AW'(14'h400 + $urandom_range(0, 15)),
               BW'($urandom), $urandom);
         set_m(1, k1[0], k1[1], $urandom_range(0, 3) == 0, AW'(14'h400 + $urandom_range(0, 15)),
               BW'($urandom), $urandom);
         tick();
      end
      reset = 1'b0;
      idle();
      for (int k = 0; k < int'(RL) + 2; k++) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
